sub_buf_pipe: RTL
=================

SUB_BUF_PIPE -- requirements
Module: sub_buf_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand width in bits.
REQ-002 SHALL have port clock  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-004 SHALL have port in_valid  input  1  operand pair on in_a/in_b is valid.
REQ-005 SHALL have port in_ready  output  1  block accepts an operand pair this cycle.
REQ-006 SHALL have port in_a  input  WIDTH  minuend, unsigned.
REQ-007 SHALL have port in_b  input  WIDTH  subtrahend, unsigned.
REQ-008 SHALL have port out_valid  output  1  out_diff holds a valid result.
REQ-009 SHALL have port out_ready  input  1  downstream consumes the result this cycle.
REQ-010 SHALL have port out_diff  output  WIDTH+1  two's-complement signed result of in_a - in_b.

Function
REQ-011 SHALL accept an operand pair when in_valid and in_ready are both 1 at a rising edge.
REQ-012 SHALL have exactly two register stages: S1 captures operands; S2 captures the computed difference.
REQ-013 SHALL compute zero-extend(in_a) - zero-extend(in_b) in WIDTH+1 bits, with no overflow possible.
REQ-014 SHALL, with out_ready held at 1, assert out_valid with the result exactly 2 cycles after acceptance.
REQ-015 SHALL sustain one accepted pair per cycle while out_ready is 1.
REQ-016 SHALL hold out_diff and out_valid stable while out_valid=1 and out_ready=0.
REQ-017 SHALL let S2 load when S2 is empty or being consumed; S1 loads when S1 is empty or S1 advances into S2.
REQ-018 SHALL drive in_ready = !S1_valid || S2_can_load, combinationally from internal state and out_ready only.
REQ-019 SHALL, under a full stall, hold both pairs and deassert in_ready; releasing out_ready SHALL drain them in order with no loss or duplication.
REQ-020 SHALL deliver results in acceptance order.
REQ-021 SHALL, for in_valid with in_ready=0, not capture the pair; the producer holds it.
REQ-022 SHALL hold out_diff at the last value when out_valid=0; that value is don't-care.

Reset
REQ-023 SHALL, when reset=0 at a rising edge, clear S1/S2 valid bits, out_valid to 0 and out_diff to 0.
REQ-024 SHALL hold in_ready at 0 during reset and raise it on the first cycle after reset=1.
REQ-025 SHALL discard in-flight data when reset is asserted mid-operation, with no partial output after reset release.

Configuration
REQ-026 SHALL support macro SUB_BUF_BORROW_OUT_EN.
REQ-027 SHALL, when SUB_BUF_BORROW_OUT_EN is defined, add output out_borrow (1 bit), equal to 1 iff in_a < in_b, pipelined alongside out_diff and reset to 0.
REQ-028 SHALL, when SUB_BUF_BORROW_OUT_EN is undefined, have no out_borrow port, with all other behaviour identical.

Structure
REQ-029 SHALL place in package sub_buf_pkg the default-width constant SUB_WIDTH=16 and the typedef for the WIDTH+1 result.
REQ-030 SHALL implement one valid/ready register slice as sub-module pipe_stage, instantiated twice; subtraction sits between the instances.

Verification
REQ-031 SHALL cover: reset=0 for 2 cycles, then release -> out_valid=0, out_diff=0, in_ready=1 on the next cycle.
REQ-032 SHALL cover streaming with out_ready=1: pairs (199,1), (199,100), (1990,183) on consecutive cycles -> out_diff 198, 99, 1807 on consecutive cycles, the first 2 cycles after its acceptance.
REQ-033 SHALL cover negative and extreme cases: (1,199) -> 17'h1FF3A (-198); (0,65535) -> 17'h10001; (65535,0) -> 17'h0FFFF; borrow 1,1,0 when enabled.
REQ-034 SHALL cover backpressure: out_ready=0 with 3 pairs offered -> in_ready falls after 2 accepted, out_diff stable; out_ready=1 -> results in order, third pair accepted.
REQ-035 SHALL cover mid-operation reset: reset=0 one cycle with 2 pairs in flight -> out_valid=0 afterwards and neither result ever appears.
REQ-036 SHALL cover random valid/ready toggling for 1000 cycles -> a scoreboard matches every result in order, with no drops or duplicates.

Source files
------------

// File: rtl/sub_buf_pkg.sv
// Shared constants and types for the sub_buf_pipe subtractor pipeline.
package sub_buf_pkg;

    localparam int SUB_WIDTH = 16;

    // Signed difference of two SUB_WIDTH-bit unsigned operands
    typedef logic [SUB_WIDTH:0] sub_diff_t;

endpackage

// File: rtl/sub_buf_pipe_stage.sv
// One valid/ready register slice; accepts when empty or when its content is being taken.
module pipe_stage
    import sub_buf_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data
);

    logic          valid_q;
    logic          valid_d;
    logic [DW-1:0] data_q;
    logic [DW-1:0] data_d;

    assign in_ready  = !valid_q || out_ready;
    assign out_valid = valid_q;
    assign out_data  = data_q;

    // Next state: load on handshake, empty when drained, otherwise hold
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (in_valid && in_ready) begin
            valid_d = 1'b1;
            data_d  = in_data;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // Slice register with synchronous active-low reset
    always_ff @(posedge clock) begin
        if (!reset) begin
            valid_q <= 1'b0;
            data_q  <= {DW{1'b0}};
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/sub_buf_pipe.sv
// Two-stage valid/ready pipelined subtractor: out_diff = in_a - in_b in WIDTH+1 bits.
// Optional macro SUB_BUF_BORROW_OUT_EN adds out_borrow (in_a < in_b) aligned with out_diff.
module sub_buf_pipe
    import sub_buf_pkg::*;
#(
    parameter int WIDTH = SUB_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   out_diff
`ifdef SUB_BUF_BORROW_OUT_EN
    ,
    output logic             out_borrow
`endif
);

    localparam int S1W = 2 * WIDTH;
`ifdef SUB_BUF_BORROW_OUT_EN
    localparam int S2W = WIDTH + 2;
`else
    localparam int S2W = WIDTH + 1;
`endif

    logic             alive_q;
    logic             s1_in_valid;
    logic             s1_in_ready;
    logic [S1W-1:0]   s1_in_data;
    logic             s1_valid;
    logic [S1W-1:0]   s1_data;
    logic             s2_in_ready;
    logic [S2W-1:0]   s2_in_data;
    logic [S2W-1:0]   s2_data;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic [WIDTH:0]   diff;
    logic             borrow;

    // Keeps in_ready low through reset and for the edge that releases it
    always_ff @(posedge clock) begin
        if (!reset) begin
            alive_q <= 1'b0;
        end else begin
            alive_q <= 1'b1;
        end
    end

    assign in_ready    = alive_q && s1_in_ready;
    assign s1_in_valid = in_valid && alive_q;
    assign s1_in_data  = {in_a, in_b};

    pipe_stage #(
        .DW (S1W)
    ) u_s1 (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (s1_in_valid),
        .in_ready  (s1_in_ready),
        .in_data   (s1_in_data),
        .out_valid (s1_valid),
        .out_ready (s2_in_ready),
        .out_data  (s1_data)
    );

    // Subtract between the slices; zero-extension makes the result fit exactly
    always_comb begin
        s1_a   = s1_data[S1W-1:WIDTH];
        s1_b   = s1_data[WIDTH-1:0];
        diff   = {1'b0, s1_a} - {1'b0, s1_b};
        borrow = (s1_a < s1_b);
`ifdef SUB_BUF_BORROW_OUT_EN
        s2_in_data = {borrow, diff};
`else
        s2_in_data = diff;
`endif
    end

    pipe_stage #(
        .DW (S2W)
    ) u_s2 (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (s1_valid),
        .in_ready  (s2_in_ready),
        .in_data   (s2_in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (s2_data)
    );

    assign out_diff = s2_data[WIDTH:0];
`ifdef SUB_BUF_BORROW_OUT_EN
    assign out_borrow = s2_data[WIDTH+1];
`endif

endmodule
